// File: rtl/digitalclock_timekeeper.sv
// digitalclock_timekeeper
//   Timekeeping datapath for the digital clock. Divides clk down to a 1 s
//   tick, runs the seconds -> minutes -> hours chain with carries, lets the
//   user bump hours or minutes with a debounced button while a set mode is
//   active, and produces a blink strobe for the digits being edited.
//
// Parameters
//   CLKS_PER_SEC  clk cycles per second; must be >= 2 and even so that the
//                 blink half-period (CLKS_PER_SEC/2) is a whole number.
//
// Ports
//   clk          in   system clock, rising edge
//   reset        in   synchronous, active-high
//   set_hours    in   hours-set mode request (wins over set_minutes)
//   set_minutes  in   minutes-set mode request
//   inc          in   increment button level (synchronised, debounced)
//   hours        out  0..23
//   minutes      out  0..59
//   seconds      out  0..59
//   sec_tick     out  one-cycle pulse per elapsed second, RUN only
//   blink        out  blink strobe, low outside set modes
module digitalclock_timekeeper #(
  parameter int CLKS_PER_SEC = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       set_hours,
  input  logic       set_minutes,
  input  logic       inc,
  output logic [4:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic       sec_tick,
  output logic       blink
);

  localparam int PRESC_W   = $clog2(CLKS_PER_SEC);
  localparam int HALF_SEC  = CLKS_PER_SEC / 2;
  localparam int BLINK_W   = (HALF_SEC > 1) ? $clog2(HALF_SEC) : 1;

  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLKS_PER_SEC - 1);
  localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(HALF_SEC - 1);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    SET_H = 2'd1,
    SET_M = 2'd2
  } mode_t;

  mode_t              mode;
  logic [PRESC_W-1:0] prescaler;
  logic [BLINK_W-1:0] blink_cnt;
  logic               inc_q;
  logic               inc_rise;
  logic               sec_wrap;
  logic               min_wrap;

  // Modulo-24 increment for the hours field.
  function automatic logic [4:0] inc_mod24(input logic [4:0] v);
    return (v == 5'd23) ? 5'd0 : v + 5'd1;
  endfunction

  // Modulo-60 increment shared by minutes and seconds.
  function automatic logic [5:0] inc_mod60(input logic [5:0] v);
    return (v == 6'd59) ? 6'd0 : v + 6'd1;
  endfunction

  // set_hours has priority when both set requests are asserted.
  always_comb begin
    mode = RUN;
    if (set_hours)
      mode = SET_H;
    else if (set_minutes)
      mode = SET_M;
  end

  // Only a 0->1 transition of the button counts, so a held button (including
  // one already held when a set mode is entered) gives no further increments.
  assign inc_rise = inc & ~inc_q;
  assign sec_wrap = (seconds == 6'd59);
  assign min_wrap = (minutes == 6'd59);

  always_ff @(posedge clk) begin
    if (reset)
      inc_q <= 1'b0;
    else
      inc_q <= inc;
  end

  // Prescaler and second tick. Outside RUN the prescaler is held at zero so
  // the first tick after leaving a set mode arrives a full second later.
  always_ff @(posedge clk) begin
    if (reset) begin
      prescaler <= '0;
      sec_tick  <= 1'b0;
    end else if (mode == RUN) begin
      if (prescaler == PRESC_MAX) begin
        prescaler <= '0;
        sec_tick  <= 1'b1;
      end else begin
        prescaler <= prescaler + PRESC_W'(1);
        sec_tick  <= 1'b0;
      end
    end else begin
      prescaler <= '0;
      sec_tick  <= 1'b0;
    end
  end

  // Time counters. In RUN every carry resolves on the tick edge itself, so
  // 23:59:59 rolls straight to 00:00:00. In set modes only the selected field
  // moves and it wraps on its own without carrying.
  always_ff @(posedge clk) begin
    if (reset) begin
      hours   <= 5'd0;
      minutes <= 6'd0;
      seconds <= 6'd0;
    end else begin
      case (mode)
        SET_H: begin
          seconds <= 6'd0;
          if (inc_rise)
            hours <= inc_mod24(hours);
        end
        SET_M: begin
          seconds <= 6'd0;
          if (inc_rise)
            minutes <= inc_mod60(minutes);
        end
        default: begin
          if (prescaler == PRESC_MAX) begin
            seconds <= inc_mod60(seconds);
            if (sec_wrap) begin
              minutes <= inc_mod60(minutes);
              if (min_wrap)
                hours <= inc_mod24(hours);
            end
          end
        end
      endcase
    end
  end

  // Blink strobe. RUN parks the counter and strobe at zero, which is what
  // makes every set-mode entry start in the same phase; moving between the
  // two set modes does not pass through RUN, so the phase carries over.
  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt <= '0;
      blink     <= 1'b0;
    end else if (mode == RUN) begin
      blink_cnt <= '0;
      blink     <= 1'b0;
    end else if (blink_cnt == BLINK_MAX) begin
      blink_cnt <= '0;
      blink     <= ~blink;
    end else begin
      blink_cnt <= blink_cnt + BLINK_W'(1);
    end
  end

endmodule

// File: tb/tb_digitalclock_timekeeper.sv
// Testbench for digitalclock_timekeeper with CLKS_PER_SEC = 4.
// Stimulus pushes expected snapshots and expected tick values into queues;
// monitor processes on the falling edge pop and compare them.
module tb_digitalclock_timekeeper;

  localparam int CPS = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       set_hours;
  logic       set_minutes;
  logic       inc;
  logic [4:0] hours;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic       sec_tick;
  logic       blink;

  digitalclock_timekeeper #(.CLKS_PER_SEC(CPS)) dut (
    .clk        (clk),
    .reset      (reset),
    .set_hours  (set_hours),
    .set_minutes(set_minutes),
    .inc        (inc),
    .hours      (hours),
    .minutes    (minutes),
    .seconds    (seconds),
    .sec_tick   (sec_tick),
    .blink      (blink)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [4:0] h;
    logic [5:0] m;
    logic [5:0] s;
    logic       tick;
    logic       chk_blink;
    logic       blink;
  } snap_t;

  typedef struct {
    logic [4:0] h;
    logic [5:0] m;
    logic [5:0] s;
  } tick_t;

  snap_t snap_q[$];
  tick_t tick_q[$];
  int    tests = 0;
  int    fails = 0;
  logic  set_at_edge = 1'b0;
  logic  prev_tick = 1'b0;

  // Mode the DUT saw on the most recent rising edge.
  always @(posedge clk) set_at_edge <= set_hours | set_minutes;

  // Snapshot monitor.
  always @(negedge clk) begin
    snap_t e;
    while (snap_q.size() > 0) begin
      e = snap_q.pop_front();
      tests++;
      if (hours !== e.h || minutes !== e.m || seconds !== e.s || sec_tick !== e.tick ||
          (e.chk_blink && blink !== e.blink)) begin
        fails++;
        $display("FAIL %s: got %0d:%0d:%0d tick=%0b blink=%0b, expected %0d:%0d:%0d tick=%0b blink=%0b",
                 e.name, hours, minutes, seconds, sec_tick, blink, e.h, e.m, e.s, e.tick, e.blink);
      end
    end
  end

  // Tick monitor and invariants.
  always @(negedge clk) begin
    tick_t t;
    if (sec_tick === 1'b1) begin
      tests++;
      if (tick_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_tick: got tick at %0d:%0d:%0d, expected no tick", hours, minutes, seconds);
      end else begin
        t = tick_q.pop_front();
        if (hours !== t.h || minutes !== t.m || seconds !== t.s) begin
          fails++;
          $display("FAIL tick_time: got %0d:%0d:%0d, expected %0d:%0d:%0d",
                   hours, minutes, seconds, t.h, t.m, t.s);
        end
      end
      tests++;
      if (set_at_edge) begin
        fails++;
        $display("FAIL tick_in_set: got tick=1 in set mode, expected 0");
      end
      tests++;
      if (prev_tick) begin
        fails++;
        $display("FAIL tick_width: got tick high two cycles, expected one");
      end
    end
    if (hours > 5'd23 || minutes > 6'd59 || seconds > 6'd59) begin
      tests++;
      fails++;
      $display("FAIL range: got %0d:%0d:%0d, expected within 23:59:59", hours, minutes, seconds);
    end
    prev_tick = sec_tick;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_now(input string name, input int h, input int m, input int s,
                            input logic tick, input logic chk_b, input logic b);
    snap_t e;
    e.name = name;
    e.h = 5'(h);
    e.m = 6'(m);
    e.s = 6'(s);
    e.tick = tick;
    e.chk_blink = chk_b;
    e.blink = b;
    snap_q.push_back(e);
  endtask

  task automatic expect_tick(input int h, input int m, input int s);
    tick_t t;
    t.h = 5'(h);
    t.m = 6'(m);
    t.s = 6'(s);
    tick_q.push_back(t);
  endtask

  task automatic pulse(input int n);
    repeat (n) begin
      inc = 1'b1;
      step(1);
      inc = 1'b0;
      step(1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic blink_seq [6];
    blink_seq = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    reset = 1'b1;
    set_hours = 1'b0;
    set_minutes = 1'b0;
    inc = 1'b0;

    // 1: reset, then free running
    step(2);
    reset = 1'b0;
    expect_now("reset_state", 0, 0, 0, 1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= 3; k++) expect_tick(0, 0, k);
    step(12);
    expect_now("run_12_cycles", 0, 0, 3, 1'b1, 1'b1, 1'b0);

    // 2: set 23:59, run one minute, full rollover
    set_hours = 1'b1;
    step(1);
    pulse(23);
    expect_now("set_hours_23", 23, 0, 0, 1'b0, 1'b0, 1'b0);
    set_hours = 1'b0;
    set_minutes = 1'b1;
    pulse(59);
    expect_now("set_minutes_59", 23, 59, 0, 1'b0, 1'b0, 1'b0);
    set_minutes = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      if (k < 60) expect_tick(23, 59, k);
      else        expect_tick(0, 0, 0);
    end
    step(240);
    expect_now("rollover", 0, 0, 0, 1'b1, 1'b1, 1'b0);

    // 3: held button gives one increment
    set_minutes = 1'b1;
    pulse(10);
    expect_now("minutes_10", 0, 10, 0, 1'b0, 1'b0, 1'b0);
    inc = 1'b1;
    step(10);
    expect_now("held_inc", 0, 11, 0, 1'b0, 1'b0, 1'b0);
    inc = 1'b0;
    step(1);
    inc = 1'b1;
    step(1);
    expect_now("repress_inc", 0, 12, 0, 1'b0, 1'b0, 1'b0);
    inc = 1'b0;
    step(1);

    // 4: hours wrap without carry, blink phase
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    pulse(7);
    set_minutes = 1'b0;
    set_hours = 1'b1;
    pulse(23);
    expect_now("hours_23_min_7", 23, 7, 0, 1'b0, 1'b0, 1'b0);
    pulse(1);
    expect_now("hours_wrap", 0, 7, 0, 1'b0, 1'b0, 1'b0);
    set_hours = 1'b0;
    step(1);
    set_hours = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) begin
        set_hours = 1'b0;
        set_minutes = 1'b1;
      end
      step(1);
      expect_now($sformatf("blink_%0d", i), 0, 7, 0, 1'b0, 1'b1, blink_seq[i]);
    end

    // 5: reset during set mode
    set_minutes = 1'b0;
    set_hours = 1'b1;
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    pulse(5);
    step(1);
    expect_now("hours_5", 5, 0, 0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    step(1);
    expect_now("reset_in_set", 0, 0, 0, 1'b0, 1'b1, 1'b0);
    reset = 1'b0;

    // 6: both set requests, held button across RUN -> SET
    set_hours = 1'b0;
    set_minutes = 1'b1;
    pulse(3);
    expect_now("minutes_3", 0, 3, 0, 1'b0, 1'b0, 1'b0);
    set_hours = 1'b1;
    pulse(1);
    expect_now("both_set", 1, 3, 0, 1'b0, 1'b0, 1'b0);
    set_hours = 1'b0;
    set_minutes = 1'b0;
    inc = 1'b1;
    step(2);
    set_hours = 1'b1;
    step(3);
    expect_now("held_across_run", 1, 3, 0, 1'b0, 1'b0, 1'b0);
    inc = 1'b0;
    step(1);
    inc = 1'b1;
    step(1);
    expect_now("press_after_release", 2, 3, 0, 1'b0, 1'b0, 1'b0);
    inc = 1'b0;
    step(2);

    tests++;
    if (snap_q.size() != 0 || tick_q.size() != 0) begin
      fails++;
      $display("FAIL queues_drained: got %0d snapshots and %0d ticks pending, expected 0 and 0",
               snap_q.size(), tick_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
